// File: rtl/gpi_rx_filter_bank.sv
// Bank of general-purpose input channels: synchroniser, enable gating, debounce
// filter, selectable edge detection and sticky interrupt status with combined IRQ.
module gpi_rx_filter_bank #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                CLK_I,
    input  logic                RST_NI,
    input  logic [N_CH-1:0]     PAD_DI_I,
    input  logic [N_CH-1:0]     EN_I,
    input  logic [CNT_W-1:0]    DEB_LEN_I,
    input  logic [2*N_CH-1:0]   EDGE_SEL_I,
    input  logic [N_CH-1:0]     IRQ_CLR_I,
    output logic [N_CH-1:0]     LEVEL_O,
    output logic [N_CH-1:0]     EDGE_O,
    output logic [N_CH-1:0]     IRQ_STAT_O,
    output logic                IRQ_O
);

    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    logic [N_CH-1:0]  r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [N_CH-1:0]  r_level;
    logic [N_CH-1:0]  r_edge;
    logic [N_CH-1:0]  r_irq_stat;

    logic [N_CH-1:0]  w_s;
    logic [CNT_W:0]   w_lim;
    logic [CNT_W:0]   w_cnt_inc [N_CH];
    logic [N_CH-1:0]  w_accept;
    logic [N_CH-1:0]  w_edge_nxt;

    // A disabled channel also flushes its synchroniser, so re-enabling with the
    // pad already high still takes the full pad-to-level latency.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of its neighbours regardless of block order.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= PAD_DI_I & EN_I;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1] & EN_I;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_accept   = '0;
        w_edge_nxt = '0;
        w_s        = r_sync[SYNC_STAGES-1] & EN_I;
        w_lim      = (DEB_LEN_I == '0) ? ONE : {1'b0, DEB_LEN_I};
        for (int ch = 0; ch < N_CH; ch++) begin
            // Extra bit keeps the increment from wrapping; >= makes a shortened
            // limit accept on the next edge when the count is already past it.
            w_cnt_inc[ch]  = {1'b0, r_cnt[ch]} + ONE;
            w_accept[ch]   = EN_I[ch] & (w_s[ch] ^ r_level[ch]) & (w_cnt_inc[ch] >= w_lim);
            w_edge_nxt[ch] = w_accept[ch] &
                             (w_s[ch] ? EDGE_SEL_I[2*ch] : EDGE_SEL_I[2*ch+1]);
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            for (int ch = 0; ch < N_CH; ch++) r_cnt[ch] <= '0;
            r_level <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (!EN_I[ch]) begin
                    r_level[ch] <= 1'b0;
                    r_cnt[ch]   <= '0;
                end else if (w_s[ch] == r_level[ch]) begin
                    r_cnt[ch]   <= '0;
                end else if (w_accept[ch]) begin
                    r_level[ch] <= w_s[ch];
                    r_cnt[ch]   <= '0;
                end else begin
                    r_cnt[ch]   <= w_cnt_inc[ch][CNT_W-1:0];
                end
            end
        end
    end

    // A new edge wins over a coincident clear.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_edge     <= '0;
            r_irq_stat <= '0;
        end else begin
            r_edge     <= w_edge_nxt;
            r_irq_stat <= (r_irq_stat & ~IRQ_CLR_I) | w_edge_nxt;
        end
    end

    assign LEVEL_O    = r_level;
    assign EDGE_O     = r_edge;
    assign IRQ_STAT_O = r_irq_stat;
    assign IRQ_O      = |r_irq_stat;

endmodule
